user_module_341063825089364563_core: RTL and testbench
======================================================

// Module: user_module_341063825089364563_core
// PURPOSE
//  Stepper-motor phase sequencer for a TinyTapeout user slot (8-in/8-out pad bus).
//  Generates a half-step drive pattern for a bipolar motor (4 coil lines).
//  Step rate is set by a 3-bit speed code; direction by one input pin.
//  Also provides a step strobe, a moving flag and phase bits for debug/LEDs.
//  All control arrives on io_in; all results leave on io_out.
// PARAMETERS
//  PRESCALE_BITS  0  extra clock divide: every step period is multiplied by 2^PRESCALE_BITS
//                    (0 for simulation; raise for real motors)
// PORTS
//  io_in[0]    in   1  clk: single clock, rising edge
//  io_in[1]    in   1  reset: synchronous, active-high
//  io_in[4:2]  in   3  speed: 0 = stopped, 1..7 = slow..fast
//  io_in[6:5]  in   2  reserved, ignored; X or Z on them must not affect outputs
//  io_in[7]    in   1  direction: 0 = forward (phase index +1), 1 = reverse (-1)
//  io_out[3:0] out  4  coil drive {B-,A-,B+,A+} from phase table
//  io_out[4]   out  1  step strobe: high for exactly 1 cycle after each step
//  io_out[5]   out  1  moving: registered (speed != 0)
//  io_out[7:6] out  2  phase index bits [2:1]
// BEHAVIOUR
//  - Every output is a register (no combinational path from io_in to io_out).
//  - Reset (sampled at the clock edge) clears all state:
//    - phase index = 0, prescaler = 0
//    - io_out = 8'b0000_0001 (coil 0001, strobe 0, moving 0, phase 00)
//  - Phase table, index 0..7 -> io_out[3:0]:
//    0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001
//  - Index is 3 bits and wraps modulo 8: 7 +1 -> 0, 0 -1 -> 7.
//  - Prescaler: (7+PRESCALE_BITS)-bit counter.
//    - Increments each clock while speed != 0.
//    - Holds its value while speed == 0.
//  - Step condition for speed s, 1..7: the low (7-s+PRESCALE_BITS) prescaler bits are all ones.
//    - Step period = 2^(7-s+PRESCALE_BITS) cycles.
//    - With PRESCALE_BITS = 0: s=7 steps every cycle; s=3 every 16 cycles; s=1 every 64 cycles.
//  - Step condition is evaluated on the pre-edge counter value.
//  - On a step, at the same edge:
//    - index <= index +/- 1, as set by the direction bit sampled at that edge
//    - coils <= table[new index]
//    - strobe <= 1
//  - At every other edge strobe <= 0.
//  - speed == 0: no steps; coils hold the last pattern (holding torque); strobe 0.
//  - Speed change: the new mask applies from the next edge; the prescaler is not cleared.
//    The first period after a change may therefore be shorter than nominal.
//  - Direction change: no extra step, no glitch; it applies from the next step.
//  - moving: registered copy of (speed != 0); it lags the speed input by 1 cycle.
//  - Reset mid-run wins over a step at the same edge and returns to index 0.
//    Stepping resumes on the first edge after reset deasserts, if speed != 0.
// TESTING  (PRESCALE_BITS = 0, 10 ns clock)
//  1. Reset 1 cycle, speed 0, dir 0 -> io_out = 0x01, stays 0x01 for 10 cycles.
//  2. Speed 7, dir 0 -> coils change every cycle 0001,0011,0010,0110,0100,1100,1000,1001,0001.
//     Strobe high every cycle; moving = 1.
//  3. Speed 3 -> exactly one step per 16 cycles (after the first, possibly short, period).
//     Strobe is a 1-cycle pulse per step.
//  4. Speed 3, switch to dir 1 -> next steps walk the table backwards, e.g. 0011 -> 0001 -> 1001.
//     Index wraps 0 -> 7.
//  5. Speed 0 mid-run -> coils frozen, strobe 0, moving drops 1 cycle later.
//     Speed 7 again resumes from the frozen index.
//  6. Reset asserted during speed 7 -> io_out = 0x01 at the next edge.
//     io_in[6:5] = X throughout produces no X on io_out.

Source files
------------

// File: rtl/user_module_341063825089364563_core.sv
// Half-step phase sequencer for a bipolar stepper motor on a TinyTapeout 8-in/8-out slot.
// The step rate comes from a power-of-two prescaler mask, and every output is registered.
module user_module_341063825089364563_core #(
    parameter int unsigned PRESCALE_BITS = 0
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int unsigned CNT_W = 7 + PRESCALE_BITS;

    logic             clk;
    logic             rst;
    logic [2:0]       speed_c;
    logic             dir_c;
    logic             unused_reserved_c;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       coil_q, coil_d;
    logic             strobe_q, strobe_d;
    logic             moving_q, moving_d;

    logic [CNT_W-1:0] mask_c;
    logic             step_c;

    assign clk               = io_in[0];
    assign rst               = io_in[1];
    assign speed_c           = io_in[4:2];
    assign dir_c             = io_in[7];
    assign unused_reserved_c = ^io_in[6:5];

    // Half-step drive pattern {B-,A-,B+,A+}.
    function automatic logic [3:0] coil_pattern(input logic [2:0] idx);
        logic [3:0] pat;
        pat = 4'b0001;
        case (idx)
            3'd0: pat = 4'b0001;
            3'd1: pat = 4'b0011;
            3'd2: pat = 4'b0010;
            3'd3: pat = 4'b0110;
            3'd4: pat = 4'b0100;
            3'd5: pat = 4'b1100;
            3'd6: pat = 4'b1000;
            3'd7: pat = 4'b1001;
            default: pat = 4'b0001;
        endcase
        return pat;
    endfunction

    // A step fires when the low (CNT_W - speed) counter bits are all ones.
    always_comb begin
        mask_c = '0;
        step_c = 1'b0;
        if (speed_c != 3'd0) begin
            mask_c = (CNT_W'(1) << (CNT_W - 32'(speed_c))) - CNT_W'(1);
            step_c = ((cnt_q & mask_c) == mask_c);
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        coil_d   = coil_q;
        strobe_d = step_c;
        moving_d = (speed_c != 3'd0);
        if (speed_c != 3'd0) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (step_c) begin
            idx_d  = dir_c ? (idx_q - 3'd1) : (idx_q + 3'd1);
            coil_d = coil_pattern(idx_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            coil_q   <= 4'b0001;
            strobe_q <= 1'b0;
            moving_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            coil_q   <= coil_d;
            strobe_q <= strobe_d;
            moving_q <= moving_d;
        end
    end

    assign io_out = {idx_q[2:1], moving_q, strobe_q, coil_q};

endmodule

// File: tb/tb_user_module_341063825089364563_core.sv
// Randomized check of the stepper sequencer against a step-count model, with literal anchors.
module tb_user_module_341063825089364563_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] speed = 3'd0;
    logic       dir = 1'b0;
    logic [1:0] res = 2'bxx;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    assign io_in = {dir, res, speed, rst, clk};

    user_module_341063825089364563_core #(.PRESCALE_BITS(0)) dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    logic [3:0] tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                            4'b0100, 4'b1100, 4'b1000, 4'b1001};

    // Model state: free-running count, phase index, last strobe/moving.
    int m_cnt = 0;
    int m_idx = 0;
    bit m_strobe = 1'b0;
    bit m_moving = 1'b0;

    always @(posedge clk) begin
        int per;
        bit stp;
        if (rst) begin
            m_cnt    <= 0;
            m_idx    <= 0;
            m_strobe <= 1'b0;
            m_moving <= 1'b0;
        end else begin
            stp = 1'b0;
            if (speed != 0) begin
                per = 1 << (7 - int'(speed));
                stp = ((m_cnt % per) == per - 1);
                m_cnt <= (m_cnt + 1) % 128;
            end
            if (stp) m_idx <= dir ? (m_idx + 7) % 8 : (m_idx + 1) % 8;
            m_strobe <= stp;
            m_moving <= (speed != 0);
        end
    end

    function automatic logic [7:0] model_out();
        logic [2:0] i;
        i = 3'(m_idx);
        return {i[2:1], m_moving, m_strobe, tbl[m_idx]};
    endfunction

    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            vectors++;
            if (io_out !== model_out()) begin
                miscompares++;
                $display("FAIL model t=%0t io_out=%b expected=%b", $time, io_out, model_out());
            end
        end
    endtask

    task automatic check_lit(input string name, input logic [7:0] mask, input logic [7:0] exp);
        vectors++;
        if ((io_out & mask) !== exp) begin
            miscompares++;
            $display("FAIL %s io_out=%b mask=%b expected=%b", name, io_out, mask, exp);
        end
    endtask

    initial begin
        logic [3:0] seq [8] = '{4'b0011, 4'b0010, 4'b0110, 4'b0100,
                                4'b1100, 4'b1000, 4'b1001, 4'b0001};
        logic [3:0] frozen;
        int strobes;

        // Reset, then idle at speed 0.
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check_lit("reset_value", 8'hFF, 8'h01);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_lit("idle_hold", 8'hFF, 8'h01);
        end

        // Full speed forward: one step per cycle.
        speed = 3'd7;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_lit("fast_fwd_coil", 8'h0F, {4'b0, seq[i]});
            check_lit("fast_fwd_strobe_moving", 8'h30, 8'h30);
        end

        // Speed 3: exactly four steps in any 64-cycle window.
        speed = 3'd3;
        strobes = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            strobes += int'(io_out[4]);
        end
        vectors++;
        if (strobes != 4) begin
            miscompares++;
            $display("FAIL speed3_rate strobes=%0d expected=4", strobes);
        end

        // Reverse direction at speed 3.
        dir = 1'b1;
        for (int i = 0; i < 80; i++) tick();

        // Stop: coils frozen, strobe and moving low after one edge.
        frozen = io_out[3:0];
        speed = 3'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_lit("stop_hold", 8'h3F, {4'b0, frozen});
        end
        speed = 3'd7;
        for (int i = 0; i < 5; i++) tick();

        // Reset mid-run wins over the step.
        rst = 1'b1;
        tick();
        check_lit("mid_reset", 8'hFF, 8'h01);
        rst = 1'b0;
        // Reverse from index 0 wraps to 7.
        dir = 1'b1;
        tick();
        check_lit("reverse_wrap", 8'hFF, 8'hF9);
        tick();
        check_lit("reverse_wrap2", 8'hFF, 8'hF8);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) speed = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) dir = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 99) == 0);
            res = 2'($urandom_range(0, 3));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
